// File: rtl/pair_triple_pattern_gen.sv
// Stimulus source for the 2-of-3 majority detector: walks 0..7 and emits each
// pattern whose popcount matches the latched request, one valid/ready beat at a time.
module pair_triple_pattern_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_val,
    output logic       req_rdy,
    input  logic [1:0] req_weight,
    input  logic       req_atleast,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [2:0] out_bits,
    output logic       out_expect,
    output logic       out_last,
    output logic [3:0] emit_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cand_q, cand_d;
    logic [1:0] wt_q, wt_d;
    logic       al_q, al_d;
    logic [3:0] emit_cnt_q, emit_cnt_d;

    logic [7:0] match_vec;
    logic [7:0] above_mask;
    logic       later_match;

    function automatic logic [1:0] pop3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic is_match(input logic [2:0] v, input logic [1:0] w, input logic al);
        return al ? (pop3(v) >= w) : (pop3(v) == w);
    endfunction

    // One match bit per candidate value; out_last looks at the ones above cand.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_match
            assign match_vec[gi] = is_match(3'(gi), wt_q, al_q);
        end
    endgenerate

    assign above_mask  = 8'hFE << cand_q;
    assign later_match = |(match_vec & above_mask);

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        wt_d       = wt_q;
        al_d       = al_q;
        emit_cnt_d = emit_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    wt_d       = req_weight;
                    al_d       = req_atleast;
                    cand_d     = 3'd0;
                    emit_cnt_d = 4'd0;
                    state_d    = SEARCH;
                end
            end
            SEARCH: begin
                if (match_vec[cand_q]) begin
                    state_d = EMIT;
                end else begin
                    cand_d = cand_q + 3'd1;
                end
            end
            EMIT: begin
                if (out_rdy) begin
                    emit_cnt_d = emit_cnt_q + 4'd1;
                    if (!later_match) begin
                        state_d = IDLE;
                    end else begin
                        cand_d  = cand_q + 3'd1;
                        state_d = SEARCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_q     <= 3'd0;
            wt_q       <= 2'd0;
            al_q       <= 1'b0;
            emit_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            wt_q       <= wt_d;
            al_q       <= al_d;
            emit_cnt_q <= emit_cnt_d;
        end
    end

    // Pattern outputs are forced to zero outside EMIT so idle cycles read clean.
    assign req_rdy    = (state_q == IDLE);
    assign out_val    = (state_q == EMIT);
    assign out_bits   = out_val ? cand_q : 3'd0;
    assign out_expect = out_val & (pop3(cand_q) >= 2'd2);
    assign out_last   = out_val & ~later_match;
    assign emit_cnt   = emit_cnt_q;

endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// Directed bench: each burst's expected pattern list is queued when the request
// is driven and popped as the generator hands patterns over.
module tb_pair_triple_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       req_val;
    logic       req_rdy;
    logic [1:0] req_weight;
    logic       req_atleast;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] out_bits;
    logic       out_expect;
    logic       out_last;
    logic [3:0] emit_cnt;

    typedef struct {
        logic [2:0] bits;
        logic       expect_bit;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pair_triple_pattern_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_weight (req_weight),
        .req_atleast(req_atleast),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_bits   (out_bits),
        .out_expect (out_expect),
        .out_last   (out_last),
        .emit_cnt   (emit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One request from accept to last handshake (or to an injected reset).
    task automatic run_burst(input logic [1:0] w, input logic al, input int stall_idx,
                             input int stall_len, input bit change_w, input int abort_idx);
        exp_t e;
        int   first_k;
        int   n_exp;
        int   r;
        int   idx;
        int   stalls;
        bit   done;
        bit   seen_first;
        exp_q.delete();
        first_k = -1;
        for (int v = 0; v < 8; v++) begin
            int p;
            p = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
            if (al ? (p >= int'(w)) : (p == int'(w))) begin
                e.bits       = 3'(v);
                e.expect_bit = (p >= 2);
                e.last       = 1'b0;
                exp_q.push_back(e);
                if (first_k < 0) first_k = v;
            end
        end
        exp_q[exp_q.size() - 1].last = 1'b1;
        n_exp = exp_q.size();

        r = 0;
        while (!req_rdy && r < 20) begin
            @(posedge clk); #1; r++;
        end
        chk("req_rdy_before_accept", req_rdy, 1);
        req_val     = 1'b1;
        req_weight  = w;
        req_atleast = al;
        out_rdy     = 1'b1;
        @(posedge clk); #1;
        req_val = 1'b0;
        if (change_w) req_weight = ~w;

        r = 0; idx = 0; stalls = 0; done = 1'b0; seen_first = 1'b0;
        while (!done && r < 80) begin
            @(posedge clk); #1; r++;
            if (out_val) begin
                if (!seen_first) begin
                    chk("first_out_val_cycle", r + 1, 2 + first_k);
                    seen_first = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    chk("extra_pattern_out_val", out_val, 0);
                    done = 1'b1;
                end else begin
                    e = exp_q[0];
                    chk("out_bits", out_bits, e.bits);
                    chk("out_expect", out_expect, e.expect_bit);
                    chk("out_last", out_last, e.last);
                    chk("emit_cnt_during_burst", emit_cnt, idx);
                    chk("req_rdy_busy", req_rdy, 0);
                    if (idx == abort_idx) begin
                        rst_n = 1'b0;
                        #1;
                        chk("abort_req_rdy", req_rdy, 1);
                        chk("abort_out_val", out_val, 0);
                        chk("abort_out_bits", out_bits, 0);
                        chk("abort_emit_cnt", emit_cnt, 0);
                        #2 rst_n = 1'b1;
                        @(posedge clk); #1;
                        chk("post_abort_out_val", out_val, 0);
                        chk("post_abort_req_rdy", req_rdy, 1);
                        $display("[TB] w=%0d al=%0d aborted by reset at pattern %0d", w, al, e.bits);
                        exp_q.delete();
                        out_rdy = 1'b1;
                        return;
                    end
                    out_rdy = !(idx == stall_idx && stalls < stall_len);
                    if (!out_rdy) begin
                        stalls++;
                    end else begin
                        $display("[TB] w=%0d al=%0d pattern=%0d expect=%0d last=%0d emit_cnt=%0d",
                                 w, al, out_bits, out_expect, out_last, emit_cnt);
                        idx++;
                        done = e.last;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_gap_out_bits", out_bits, 0);
                chk("idle_gap_out_last", out_last, 0);
                chk("idle_gap_out_expect", out_expect, 0);
                chk("req_rdy_busy_gap", req_rdy, 0);
            end
        end
        if (!done) begin
            chk("burst_timeout_patterns", idx, n_exp);
        end else begin
            @(posedge clk); #1;
            chk("end_req_rdy", req_rdy, 1);
            chk("end_out_val", out_val, 0);
            chk("end_emit_cnt", emit_cnt, n_exp);
            @(posedge clk); #1;
            chk("idle_hold_emit_cnt", emit_cnt, n_exp);
        end
        out_rdy = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        req_val     = 1'b0;
        req_weight  = 2'd0;
        req_atleast = 1'b0;
        out_rdy     = 1'b1;

        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("reset_req_rdy", req_rdy, 1);
        chk("reset_out_val", out_val, 0);
        chk("reset_out_bits", out_bits, 0);
        chk("reset_out_expect", out_expect, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_emit_cnt", emit_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_req_rdy", req_rdy, 1);
        chk("release_out_val", out_val, 0);

        run_burst(2'd2, 1'b0, -1, 0, 1'b0, -1);
        run_burst(2'd2, 1'b1, -1, 0, 1'b0, -1);
        run_burst(2'd0, 1'b1, -1, 0, 1'b0, -1);
        run_burst(2'd0, 1'b0, -1, 0, 1'b0, -1);
        run_burst(2'd3, 1'b0, -1, 0, 1'b0, -1);
        run_burst(2'd1, 1'b0, 0, 5, 1'b1, -1);
        run_burst(2'd1, 1'b1, -1, 0, 1'b0, 1);
        run_burst(2'd3, 1'b0, -1, 0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_triple_pattern_gen.md
# pair_triple_pattern_gen

Sequential stimulus source for the pair/triple (2-of-3 majority) detection path. On an accepted request it enumerates, in ascending binary order, every 3-bit pattern whose popcount equals the requested weight (exact mode) or is at least that weight (at-least mode). It emits each pattern over a valid/ready stream, with the expected detector result and an end-of-burst flag. It feeds detector instances and their self-checking benches.

## Interface
Parameters: none.
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_val`  in  1  request valid
- `req_rdy`  out  1  request ready; high only in IDLE
- `req_weight`  in  2  requested popcount, 0..3
- `req_atleast`  in  1  0 = popcount == weight; 1 = popcount >= weight
- `out_val`  out  1  pattern valid
- `out_rdy`  in  1  consumer ready
- `out_bits`  out  3  pattern; bit0/1/2 drive detector in0/in1/in2
- `out_expect`  out  1  popcount(out_bits) >= 2
- `out_last`  out  1  no later pattern in this burst matches
- `emit_cnt`  out  4  patterns handshaken since the last request accept

## Operation
- Request fields: `req_weight` and `req_atleast` are latched into `wt_q` and `al_q` when `req_val && req_rdy`. Later changes on those inputs have no effect until the next accept.
- Candidate counter: `cand` is 3 bits. It is cleared on accept and incremented only when leaving EMIT via a non-last handshake, or when leaving SEARCH on a non-match. It never wraps within a burst.
- Match condition: `match = al_q ? (pop(cand) >= wt_q) : (pop(cand) == wt_q)`. Every legal request has at least one match, so SEARCH always terminates by cand = 7.
- FSM states:
  - IDLE: `req_rdy` = 1. On accept, go to SEARCH with `cand` = 0 and `emit_cnt` = 0.
  - SEARCH: if `match`, go to EMIT with `cand` unchanged. Otherwise `cand++` and stay in SEARCH.
  - EMIT: `out_val` = 1 and `out_bits` = `cand`. On `out_rdy`:
    - `emit_cnt++`.
    - If `out_last`, go to IDLE.
    - Else `cand++` and go to SEARCH.
    - Without `out_rdy`, hold everything.
- `out_last` is combinational from `cand`, `wt_q` and `al_q`: it is 1 iff no value in `cand+1` through 7 matches. It is 1 when `cand` = 7.
- `out_bits`, `out_expect` and `out_last` are 0 when `out_val` = 0.
- `emit_cnt` holds its final value in IDLE until the next accept. Maximum value is 8, which fits in 4 bits.
- Reset: async assert forces IDLE with `cand`, `wt_q`, `al_q` and `emit_cnt` all 0. Resulting outputs: `req_rdy` = 1, `out_val` = 0, `out_bits` = 0, `out_expect` = 0, `out_last` = 0, `emit_cnt` = 0. This applies mid-burst as well; the partial burst is discarded with no further `out_val`. Deassertion is followed by normal operation on the next edge.

## Timing
- Accept at edge T: SEARCH begins at cycle T+1 with `cand` = 0.
- First pattern `k`: `out_val` rises at T+2+k.
- Between consecutive matches `a < b`: the handshake at edge H gives next `out_val` at H+1+(b−a). Adjacent matches give a 1-cycle bubble, so there is no back-to-back streaming; this is intended.
- Burst end: a last handshake at edge H gives IDLE, with `req_rdy` = 1, at H+1. A new request can be accepted at H+1.
- `req_rdy` is 0 from T+1 until the burst returns to IDLE.
- Backpressure: `out_val`, `out_bits`, `out_expect` and `out_last` stay stable while `out_rdy` = 0. There is no combinational path from `out_rdy` to `out_val`.

## Test plan
- Reset: hold `rst_n` low mid-clock → outputs immediately at reset values. Release → `req_rdy` = 1, `out_val` = 0.
- Exact weight 2, `out_rdy` = 1:
  - `out_bits` sequence is 3, 5, 6, each with `out_expect` = 1.
  - `out_last` only on 6; final `emit_cnt` = 3.
  - Accept at T gives first `out_val` at T+5.
- At-least weight 2: sequence 3, 5, 6, 7 with last on 7, `emit_cnt` = 4. At-least weight 0: all 0..7 in order, `out_expect` = 1 exactly for 3, 5, 6, 7, `emit_cnt` = 8.
- Exact weight 0: single pattern 0 at T+2 with `out_last` = 1 and `out_expect` = 0. Exact weight 3: single pattern 7 at T+9, last = 1.
- Backpressure on exact weight 1:
  - Hold `out_rdy` = 0 for 5 cycles at pattern 1 → `out_bits` = 1 held and `emit_cnt` unchanged.
  - Then 1, 2, 4 complete.
  - Changing `req_weight` mid-burst has no effect.
- Reset mid-EMIT of at-least weight 1 at pattern 2 → immediate IDLE, `emit_cnt` = 0. A new exact weight 3 request then yields pattern 7 only.
